// File: rtl/dequeue_agent_v1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dequeue_agent_v1 : round-robin PIFO-head dequeue, streams the selected
//                    port's packet buffer onto a single AXI4-Stream master.
// Revision 1.0
// ============================================================================

module dequeue_agent_v1 #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS            = 5,
  parameter int DST_POS              = 24,
  parameter int PIFO_WAIT_MAX        = 15
) (
  input  logic                                      axis_aclk,
  input  logic                                      axis_resetn,
  input  logic [NUM_PORTS-1:0]                      s_axis_pifo_empty,
  input  logic [NUM_PORTS-1:0]                      s_axis_pifo_out_valid,
  output logic [NUM_PORTS-1:0]                      m_axis_ctl_pifo_out_en,
  input  logic [NUM_PORTS-1:0]                      s_axis_buffer_empty,
  input  logic [NUM_PORTS*C_M_AXIS_DATA_WIDTH-1:0]  s_axis_buffer_tdata,
  input  logic [NUM_PORTS*C_M_AXIS_DATA_WIDTH/8-1:0] s_axis_buffer_tkeep,
  input  logic [NUM_PORTS-1:0]                      s_axis_buffer_tlast,
  output logic [NUM_PORTS-1:0]                      m_axis_ctl_buffer_rd_en,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]          m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic                                      m_axis_tlast,
  output logic                                      m_axis_ctl_deq_timeout
);

  localparam int DW     = C_M_AXIS_DATA_WIDTH;
  localparam int KW     = C_M_AXIS_DATA_WIDTH / 8;
  localparam int SEL_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int WAIT_W = $clog2(PIFO_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(PIFO_WAIT_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_SEND = 2'd3
  } state_t;

  state_t                r_state;
  logic [SEL_W-1:0]      r_rr;
  logic [SEL_W-1:0]      r_sel;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [NUM_PORTS-1:0]  r_pifo_out_en;
  logic                  r_deq_timeout;

  logic [NUM_PORTS-1:0]  w_eligible;
  logic                  w_found;
  logic [SEL_W-1:0]      w_pick;
  logic [SEL_W-1:0]      w_cand;
  logic                  w_handshake;

  function automatic logic [SEL_W-1:0] next_port(input logic [SEL_W-1:0] p);
    return (p == SEL_W'(NUM_PORTS - 1)) ? '0 : p + SEL_W'(1);
  endfunction

  function automatic logic [NUM_PORTS-1:0] one_hot(input logic [SEL_W-1:0] p);
    return NUM_PORTS'(1) << p;
  endfunction

  assign w_eligible = ~s_axis_pifo_empty & ~s_axis_buffer_empty;

  // Scan all ports starting at the rr pointer; first eligible hit wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr;
    w_cand  = r_rr;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!w_found && w_eligible[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
      w_cand = next_port(w_cand);
    end
  end

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    if (r_state == ST_SEND) begin
      m_axis_tvalid = !s_axis_buffer_empty[r_sel];
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (r_sel == SEL_W'(i)) begin
          m_axis_tdata              = s_axis_buffer_tdata[i*DW +: DW];
          m_axis_tkeep              = s_axis_buffer_tkeep[i*KW +: KW];
          m_axis_tlast              = s_axis_buffer_tlast[i];
          m_axis_tuser[DST_POS+2*i] = 1'b1;
        end
      end
    end
  end

  assign w_handshake             = m_axis_tvalid && m_axis_tready;
  assign m_axis_ctl_buffer_rd_en = w_handshake ? one_hot(r_sel) : '0;
  assign m_axis_ctl_pifo_out_en  = r_pifo_out_en;
  assign m_axis_ctl_deq_timeout  = r_deq_timeout;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_state       <= ST_IDLE;
      r_rr          <= '0;
      r_sel         <= '0;
      r_wait_cnt    <= '0;
      r_pifo_out_en <= '0;
      r_deq_timeout <= 1'b0;
    end else begin
      r_pifo_out_en <= '0;
      r_deq_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_sel         <= w_pick;
            r_pifo_out_en <= one_hot(w_pick);
            r_state       <= ST_DEQ;
          end
        end
        ST_DEQ: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (s_axis_pifo_out_valid[r_sel]) begin
            r_state <= ST_SEND;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            // Give up on a silent PIFO and move past it so other ports get served.
            if (r_wait_cnt == C_WAIT_LAST) begin
              r_deq_timeout <= 1'b1;
              r_rr          <= next_port(r_sel);
              r_state       <= ST_IDLE;
            end
          end
        end
        ST_SEND: begin
          if (w_handshake && m_axis_tlast) begin
            r_rr    <= next_port(r_sel);
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dequeue_agent_v1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_dequeue_agent_v1 : directed bench with FWFT buffer and PIFO models.
// Revision 1.0
// ============================================================================

module tb_dequeue_agent_v1;

  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int UW = 128;
  localparam int NP = 5;
  localparam int DST = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NP-1:0]    pifo_empty, pifo_out_valid, pifo_out_en;
  logic [NP-1:0]    buf_empty, buf_tlast, rd_en;
  logic [NP*DW-1:0] buf_tdata;
  logic [NP*KW-1:0] buf_tkeep;
  logic [DW-1:0]    tdata;
  logic [KW-1:0]    tkeep;
  logic [UW-1:0]    tuser;
  logic             tvalid, tready, tlast, deq_timeout;

  dequeue_agent_v1 dut (
    .axis_aclk               (clk),
    .axis_resetn             (rst_n),
    .s_axis_pifo_empty       (pifo_empty),
    .s_axis_pifo_out_valid   (pifo_out_valid),
    .m_axis_ctl_pifo_out_en  (pifo_out_en),
    .s_axis_buffer_empty     (buf_empty),
    .s_axis_buffer_tdata     (buf_tdata),
    .s_axis_buffer_tkeep     (buf_tkeep),
    .s_axis_buffer_tlast     (buf_tlast),
    .m_axis_ctl_buffer_rd_en (rd_en),
    .m_axis_tdata            (tdata),
    .m_axis_tkeep            (tkeep),
    .m_axis_tuser            (tuser),
    .m_axis_tvalid           (tvalid),
    .m_axis_tready           (tready),
    .m_axis_tlast            (tlast),
    .m_axis_ctl_deq_timeout  (deq_timeout)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } obs_t;

  beat_t bq [NP][$];
  obs_t  log_q[$];
  int    pifo_cnt[NP];
  bit    resp_en[NP];
  int    en_cnt[NP];
  int    rd_cnt[NP];
  int    to_cnt, cyc, last_en_cyc, last_to_cyc;
  logic [NP-1:0] en_seen, rd_seen;
  int    tests, fails;

  function automatic logic [DW-1:0] mk_data(int p, int b);
    logic [31:0] w;
    w = 32'hD000_0000 | 32'(p * 256) | 32'(b);
    return {8{w}};
  endfunction

  function automatic logic [KW-1:0] mk_keep(bit last);
    return last ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [UW-1:0] exp_user(int p);
    logic [UW-1:0] u;
    u = '0;
    u[DST + 2*p] = 1'b1;
    return u;
  endfunction

  task automatic refresh();
    for (int i = 0; i < NP; i++) begin
      pifo_empty[i] = (pifo_cnt[i] == 0);
      buf_empty[i]  = (bq[i].size() == 0);
      if (bq[i].size() != 0) begin
        buf_tdata[i*DW +: DW] = bq[i][0].data;
        buf_tkeep[i*KW +: KW] = bq[i][0].keep;
        buf_tlast[i]          = bq[i][0].last;
      end else begin
        buf_tdata[i*DW +: DW] = '0;
        buf_tkeep[i*KW +: KW] = '0;
        buf_tlast[i]          = 1'b0;
      end
    end
  endtask

  task automatic push_beat(int p, int b, int n);
    beat_t x;
    x.data = mk_data(p, b);
    x.keep = mk_keep(b == n - 1);
    x.last = (b == n - 1);
    bq[p].push_back(x);
  endtask

  task automatic push_pkt(int p, int n);
    for (int b = 0; b < n; b++) push_beat(p, b, n);
    pifo_cnt[p]++;
    refresh();
  endtask

  task automatic clear_stats();
    for (int i = 0; i < NP; i++) begin
      en_cnt[i] = 0;
      rd_cnt[i] = 0;
    end
    to_cnt = 0;
    log_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_log(int n, int budget, string name);
    int k;
    k = 0;
    while (log_q.size() < n && k < budget) begin
      step();
      k++;
    end
    tests++;
    if (log_q.size() < n) begin
      fails++;
      $display("FAIL %s: beats seen %0d, required %0d within %0d cycles", name, log_q.size(), n, budget);
    end
  endtask

  // FWFT buffer / PIFO model: pops and responses land just after the edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    pifo_out_valid = '0;
    for (int i = 0; i < NP; i++) begin
      if (rd_seen[i] && bq[i].size() != 0) void'(bq[i].pop_front());
      if (en_seen[i]) begin
        if (pifo_cnt[i] > 0) pifo_cnt[i]--;
        if (resp_en[i]) pifo_out_valid[i] = 1'b1;
      end
    end
    refresh();
  end

  always @(negedge clk) begin
    obs_t o;
    en_seen = pifo_out_en;
    rd_seen = rd_en;
    for (int i = 0; i < NP; i++) begin
      if (pifo_out_en[i]) en_cnt[i]++;
      if (rd_en[i]) rd_cnt[i]++;
    end
    if (|pifo_out_en) last_en_cyc = cyc;
    if (deq_timeout) begin
      to_cnt++;
      last_to_cyc = cyc;
    end
    if (tvalid && tready) begin
      o.data = tdata; o.keep = tkeep; o.user = tuser; o.last = tlast;
      log_q.push_back(o);
    end
    tests++;
    if ($countones(rd_en) > 1 || $countones(pifo_out_en) > 1 || (|rd_en && |pifo_out_en) ||
        ((|rd_en) != (tvalid && tready))) begin
      fails++;
      $display("FAIL strobe_rules: rd_en=%b pifo_out_en=%b tvalid=%b tready=%b", rd_en, pifo_out_en, tvalid, tready);
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    tready = 1'b1;
    pifo_out_valid = '0;
    for (int i = 0; i < NP; i++) begin
      pifo_cnt[i] = 0;
      resp_en[i] = 1'b1;
    end
    clear_stats();
    push_pkt(0, 2);
    repeat (3) @(negedge clk);
    tests++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || deq_timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl: tvalid=%b tlast=%b timeout=%b, required 0", tvalid, tlast, deq_timeout);
    end
    tests++;
    if (tdata !== '0 || tkeep !== '0 || tuser !== '0) begin
      fails++;
      $display("FAIL reset_data: tdata=%h tuser=%h, required 0", tdata, tuser);
    end
    tests++;
    if (pifo_out_en !== '0 || rd_en !== '0) begin
      fails++;
      $display("FAIL reset_strobes: pifo_out_en=%b rd_en=%b, required 0", pifo_out_en, rd_en);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single_port();
    wait_log(2, 20, "single_beats");
    repeat (3) step();
    tests++;
    if (log_q.size() != 2 || log_q[0].data !== mk_data(0, 0) || log_q[0].last !== 1'b0 ||
        log_q[0].keep !== mk_keep(0)) begin
      fails++;
      $display("FAIL single_beat0: data=%h last=%b, required %h last=0", log_q[0].data, log_q[0].last, mk_data(0, 0));
    end
    tests++;
    if (log_q[1].data !== mk_data(0, 1) || log_q[1].last !== 1'b1 || log_q[1].keep !== mk_keep(1)) begin
      fails++;
      $display("FAIL single_beat1: data=%h keep=%h last=%b, required %h %h 1", log_q[1].data, log_q[1].keep, log_q[1].last, mk_data(0, 1), mk_keep(1));
    end
    tests++;
    if (log_q[0].user !== exp_user(0) || log_q[1].user !== exp_user(0)) begin
      fails++;
      $display("FAIL single_tuser: got %h, required %h", log_q[0].user, exp_user(0));
    end
    tests++;
    if (en_cnt[0] != 1 || en_cnt[1] + en_cnt[2] + en_cnt[3] + en_cnt[4] != 0) begin
      fails++;
      $display("FAIL single_pifo_en: port0 pulses %0d, required 1", en_cnt[0]);
    end
    tests++;
    if (rd_cnt[0] != 2) begin
      fails++;
      $display("FAIL single_rd_en: got %0d pops, required 2", rd_cnt[0]);
    end
  endtask

  // rr is 1 after the previous packet, so port 0 is served last.
  task automatic test_round_robin();
    int order[4];
    int idx;
    order = '{1, 2, 3, 0};
    clear_stats();
    for (int p = 0; p < 4; p++) push_beat(p, 0, 3);
    for (int p = 0; p < 4; p++) begin
      push_beat(p, 1, 3);
      push_beat(p, 2, 3);
      pifo_cnt[p]++;
    end
    refresh();
    wait_log(12, 80, "rr_beats");
    for (int j = 0; j < 4; j++) begin
      for (int b = 0; b < 3; b++) begin
        idx = j * 3 + b;
        tests++;
        if (log_q[idx].data !== mk_data(order[j], b) || log_q[idx].user !== exp_user(order[j]) ||
            log_q[idx].last !== (b == 2)) begin
          fails++;
          $display("FAIL rr_beat%0d: data=%h user=%h, required %h %h", idx, log_q[idx].data, log_q[idx].user, mk_data(order[j], b), exp_user(order[j]));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_stats();
    push_pkt(3, 3);
    wait_log(1, 20, "bp_first");
    tready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      tests++;
      if (tvalid !== 1'b1 || tdata !== mk_data(3, 1) || tuser !== exp_user(3) || tlast !== 1'b0 || rd_en !== '0) begin
        fails++;
        $display("FAIL bp_hold%0d: tvalid=%b tdata=%h rd_en=%b, required 1 %h 00000", s, tvalid, tdata, rd_en, mk_data(3, 1));
      end
      step();
    end
    tready = 1'b1;
    wait_log(3, 20, "bp_beats");
    repeat (2) step();
    tests++;
    if (log_q.size() != 3 || log_q[1].data !== mk_data(3, 1) || log_q[2].data !== mk_data(3, 2) || log_q[2].last !== 1'b1) begin
      fails++;
      $display("FAIL bp_data: beat2=%h last=%b, required %h 1", log_q[2].data, log_q[2].last, mk_data(3, 2));
    end
    tests++;
    if (rd_cnt[3] != 3) begin
      fails++;
      $display("FAIL bp_rd_en: got %0d pops, required 3", rd_cnt[3]);
    end
  endtask

  task automatic test_timeout();
    int k;
    clear_stats();
    resp_en[4] = 1'b0;
    push_pkt(4, 1);
    k = 0;
    while (to_cnt == 0 && k < 40) begin
      step();
      k++;
    end
    repeat (5) step();
    tests++;
    if (to_cnt != 1) begin
      fails++;
      $display("FAIL timeout_pulses: got %0d, required 1", to_cnt);
    end
    tests++;
    if (last_to_cyc - last_en_cyc != 16) begin
      fails++;
      $display("FAIL timeout_latency: got %0d cycles after request, required 16", last_to_cyc - last_en_cyc);
    end
    tests++;
    if (log_q.size() != 0 || en_cnt[4] != 1) begin
      fails++;
      $display("FAIL timeout_quiet: beats=%0d requests=%0d, required 0 1", log_q.size(), en_cnt[4]);
    end
    resp_en[4] = 1'b1;
    bq[4].delete();
    refresh();
  endtask

  task automatic test_bubble();
    clear_stats();
    push_beat(2, 0, 3);
    pifo_cnt[2]++;
    refresh();
    wait_log(1, 20, "bubble_first");
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      tests++;
      if (tvalid !== 1'b0 || rd_en !== '0) begin
        fails++;
        $display("FAIL bubble_gap%0d: tvalid=%b rd_en=%b, required 0", s, tvalid, rd_en);
      end
    end
    step();
    push_beat(2, 1, 3);
    push_beat(2, 2, 3);
    refresh();
    wait_log(3, 20, "bubble_beats");
    tests++;
    if (log_q[1].data !== mk_data(2, 1) || log_q[1].last !== 1'b0 || log_q[2].data !== mk_data(2, 2) ||
        log_q[2].last !== 1'b1 || log_q[2].user !== exp_user(2)) begin
      fails++;
      $display("FAIL bubble_tail: beat2=%h last=%b, required %h 1", log_q[2].data, log_q[2].last, mk_data(2, 2));
    end
  endtask

  task automatic test_reset_mid_send();
    clear_stats();
    push_pkt(1, 4);
    wait_log(1, 20, "rst_first");
    tests++;
    if (tvalid !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre: tvalid=%b, required 1", tvalid);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (tvalid !== 1'b0 || tdata !== '0 || tkeep !== '0 || tuser !== '0 || tlast !== 1'b0 ||
        rd_en !== '0 || pifo_out_en !== '0 || deq_timeout !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: tvalid=%b tuser=%h rd_en=%b, required all 0", tvalid, tuser, rd_en);
    end
    repeat (2) step();
    for (int i = 0; i < NP; i++) begin
      bq[i].delete();
      pifo_cnt[i] = 0;
    end
    refresh();
    clear_stats();
    rst_n = 1'b1;
    step();
    push_pkt(2, 1);
    push_pkt(4, 1);
    wait_log(2, 30, "rst_restart");
    tests++;
    if (log_q[0].user !== exp_user(2) || log_q[1].user !== exp_user(4) || log_q[0].data !== mk_data(2, 0)) begin
      fails++;
      $display("FAIL rst_rr_restart: first user=%h, required %h", log_q[0].user, exp_user(2));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    last_en_cyc = 0;
    last_to_cyc = 0;
    en_seen = '0;
    rd_seen = '0;
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_bubble();
    test_reset_mid_send();
    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
